// File: rtl/tx_frame_ctrl.sv
// tx_frame_ctrl
//   Single-frame transmit sequencer. It accepts a 32-bit payload, streams it
//   MSB first into an external serial CRC engine, and builds a 48-bit word
//   {payload, crc}. It hands that word to an external FEC engine, waits for
//   the engine's result with a timeout, and presents the 96-bit coded frame
//   on an output handshake.
//
// Ports
//   clk, reset            : system clock, synchronous active-high reset
//   in_valid/in_ready     : payload handshake, in_data[31:0]
//   crc_start/en/bit      : CRC engine init strobe, shift enable, serial data
//   crc_value[15:0]       : CRC register from the engine
//   fec_start, fec_word   : FEC engine strobe and its 48-bit input
//   fec_done, fec_data    : FEC completion and its 96-bit result
//   out_valid/out_ready   : coded frame handshake, out_data[95:0]
//   busy, err, frame_cnt  : status: frame in flight, timeout pulse, frames sent
module tx_frame_ctrl #(
   parameter int unsigned TIMEOUT_CYC = 255
) (
   input  logic        clk,
   input  logic        reset,
   input  logic        in_valid,
   output logic        in_ready,
   input  logic [31:0] in_data,
   output logic        crc_start,
   output logic        crc_en,
   output logic        crc_bit,
   input  logic [15:0] crc_value,
   output logic        fec_start,
   output logic [47:0] fec_word,
   input  logic        fec_done,
   input  logic [95:0] fec_data,
   output logic        out_valid,
   input  logic        out_ready,
   output logic [95:0] out_data,
   output logic        busy,
   output logic        err,
   output logic [15:0] frame_cnt
);

   typedef enum logic [2:0] {
      IDLE, CRC_INIT, CRC_SHIFT, CRC_CAP, FEC_START, FEC_WAIT, OUT_HOLD
   } state_t;

   state_t      state, state_nx;
   logic [31:0] payload;
   logic [4:0]  bit_cnt;
   logic [7:0]  wait_cnt;
   logic [4:0]  shift_idx;
   logic        timeout;
   logic        crc_start_nx, crc_en_nx, crc_bit_nx, fec_start_nx, err_nx;

   // wait_cnt is 1 in the first FEC_WAIT cycle, so equality marks the last
   // cycle the engine is allowed to answer in.
   assign timeout = (wait_cnt == 8'(TIMEOUT_CYC));

   // State register, strobe registers and datapath.
   always_ff @(posedge clk) begin
      if (reset) begin
         state     <= IDLE;
         payload   <= '0;
         bit_cnt   <= '0;
         wait_cnt  <= '0;
         crc_start <= 1'b0;
         crc_en    <= 1'b0;
         crc_bit   <= 1'b0;
         fec_start <= 1'b0;
         err       <= 1'b0;
         fec_word  <= '0;
         out_data  <= '0;
         frame_cnt <= '0;
      end else begin
         state     <= state_nx;
         crc_start <= crc_start_nx;
         crc_en    <= crc_en_nx;
         crc_bit   <= crc_bit_nx;
         fec_start <= fec_start_nx;
         err       <= err_nx;

         if (state == IDLE && in_valid)
            payload <= in_data;

         bit_cnt <= (state == CRC_SHIFT) ? bit_cnt + 5'd1 : 5'd0;

         if (state == FEC_START)
            wait_cnt <= 8'd1;
         else if (state == FEC_WAIT)
            wait_cnt <= wait_cnt + 8'd1;
         else
            wait_cnt <= 8'd0;

         // fec_word then holds until the next frame reaches CRC_CAP.
         if (state == CRC_CAP)
            fec_word <= {payload, crc_value};

         if (state == FEC_WAIT && fec_done)
            out_data <= fec_data;

         if (state == OUT_HOLD && out_ready)
            frame_cnt <= frame_cnt + 16'd1;
      end
   end

   // Next-state logic.
   always_comb begin
      state_nx = state;
      case (state)
         IDLE:      if (in_valid) state_nx = CRC_INIT;
         CRC_INIT:  state_nx = CRC_SHIFT;
         CRC_SHIFT: if (bit_cnt == 5'd31) state_nx = CRC_CAP;
         CRC_CAP:   state_nx = FEC_START;
         FEC_START: state_nx = FEC_WAIT;
         // A result arriving on the expiry cycle still wins over the timeout.
         FEC_WAIT: begin
            if (fec_done)     state_nx = OUT_HOLD;
            else if (timeout) state_nx = IDLE;
         end
         OUT_HOLD:  if (out_ready) state_nx = IDLE;
         default:   state_nx = IDLE;
      endcase
   end

   // Output logic. Strobes are computed from the upcoming state so that the
   // registered copies line up with the state they belong to.
   always_comb begin
      shift_idx    = (state == CRC_SHIFT) ? bit_cnt + 5'd1 : 5'd0;
      crc_start_nx = (state_nx == CRC_INIT);
      crc_en_nx    = (state_nx == CRC_SHIFT);
      crc_bit_nx   = (state_nx == CRC_SHIFT) ? payload[~shift_idx] : 1'b0;
      fec_start_nx = (state_nx == FEC_START);
      err_nx       = (state == FEC_WAIT) && !fec_done && timeout;
   end

   assign in_ready  = (state == IDLE);
   assign busy      = (state != IDLE);
   assign out_valid = (state == OUT_HOLD);

endmodule
